unstripe_ctrl: RTL and testbench

UNSTRIPE_CTRL -- requirements
Module: unstripe_ctrl

---
 rtl/unstripe_pkg.sv | 24 ++
 rtl/lane_fifo.sv | 82 ++++++++
 rtl/unstripe_ctrl.sv | 177 +++++++++++++++++
 tb/tb_unstripe_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/unstripe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | unstripe_pkg : FSM state type, default geometry, occupancy helper    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package unstripe_pkg;

    localparam int C_DEFAULT_WIDTH    = 32;
    localparam int C_DEFAULT_DEPTH    = 4;
    localparam int C_DEFAULT_SKEW_MAX = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_L0 = 2'd1,
        RUN_L1 = 2'd2,
        ERR    = 2'd3
    } state_e;

    function automatic int occ_diff(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lane_fifo : per-lane word FIFO with synchronous flush (DEPTH >= 2)   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module lane_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [WIDTH-1:0]       head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             w_push_acc;
    logic             w_pop_acc;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full FIFO still takes a push when the same edge pops a word.
    assign w_pop_acc  = pop_i && !empty_o;
    assign w_push_acc = push_i && (!full_o || w_pop_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push_acc) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (w_pop_acc) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(w_push_acc) - CW'(w_pop_acc);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_acc && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/unstripe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | unstripe_ctrl : merges two striped lanes back into lane0/lane1 order |
// | Option UNSTRIPE_ERR_CNT_EN adds an 8-bit saturating err_count port.  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module unstripe_ctrl
    import unstripe_pkg::*;
#(
    parameter int WIDTH    = C_DEFAULT_WIDTH,
    parameter int DEPTH    = C_DEFAULT_DEPTH,
    parameter int SKEW_MAX = C_DEFAULT_SKEW_MAX
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             valid_0,
    input  logic [WIDTH-1:0] lane_0,
    input  logic             valid_1,
    input  logic [WIDTH-1:0] lane_1,
    input  logic             ready_in,
    input  logic             clear_err,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             lane_err,
    output logic             idle
`ifdef UNSTRIPE_ERR_CNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e           state_q;
    state_e           state_d;
    logic             lane_err_q;
    logic             lane_err_d;

    logic             w_push0;
    logic             w_push1;
    logic             w_pop0;
    logic             w_pop1;
    logic             w_full0;
    logic             w_full1;
    logic             w_empty0;
    logic             w_empty1;
    logic [CW-1:0]    w_cnt0;
    logic [CW-1:0]    w_cnt1;
    logic [WIDTH-1:0] w_head0;
    logic [WIDTH-1:0] w_head1;
    logic             w_acc0;
    logic             w_acc1;
    logic             w_ovf;
    logic [CW-1:0]    w_occ0;
    logic [CW-1:0]    w_occ1;
    logic             w_skew;
    logic             w_err_evt;

    assign w_push0 = valid_0 && (state_q != ERR);
    assign w_push1 = valid_1 && (state_q != ERR);
    assign w_pop0  = (state_q == RUN_L0) && ready_in;
    assign w_pop1  = (state_q == RUN_L1) && ready_in;

    // Occupancy as it will stand after this edge's push/pop, used for skew.
    assign w_acc0 = w_push0 && (!w_full0 || w_pop0);
    assign w_acc1 = w_push1 && (!w_full1 || w_pop1);
    assign w_occ0 = w_cnt0 + CW'(w_acc0) - CW'(w_pop0);
    assign w_occ1 = w_cnt1 + CW'(w_acc1) - CW'(w_pop1);
    assign w_ovf  = (w_push0 && w_full0 && !w_pop0) ||
                    (w_push1 && w_full1 && !w_pop1);
    assign w_skew = occ_diff(int'(w_occ0), int'(w_occ1)) > SKEW_MAX;

    assign w_err_evt = (state_q != ERR) && (w_ovf || w_skew);

    lane_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk     (clk),
        .rst_n   (reset_L),
        .push_i  (w_push0),
        .data_i  (lane_0),
        .pop_i   (w_pop0),
        .flush_i (w_err_evt),
        .full_o  (w_full0),
        .empty_o (w_empty0),
        .count_o (w_cnt0),
        .head_o  (w_head0)
    );

    lane_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk     (clk),
        .rst_n   (reset_L),
        .push_i  (w_push1),
        .data_i  (lane_1),
        .pop_i   (w_pop1),
        .flush_i (w_err_evt),
        .full_o  (w_full1),
        .empty_o (w_empty1),
        .count_o (w_cnt1),
        .head_o  (w_head1)
    );

    always_comb begin
        state_d    = state_q;
        lane_err_d = lane_err_q;
        valid_out  = 1'b0;
        data_out   = '0;
        case (state_q)
            IDLE: begin
                if (!w_empty0 && !w_empty1) begin
                    state_d = RUN_L0;
                end
            end
            RUN_L0: begin
                valid_out = 1'b1;
                data_out  = w_head0;
                if (ready_in) begin
                    state_d = RUN_L1;
                end
            end
            RUN_L1: begin
                valid_out = 1'b1;
                data_out  = w_head1;
                if (ready_in) begin
                    state_d = ((w_occ0 != '0) && (w_occ1 != '0)) ? RUN_L0 : IDLE;
                end
            end
            ERR: begin
                if (clear_err) begin
                    state_d    = IDLE;
                    lane_err_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // An error on this edge wins over every other transition.
        if (w_err_evt) begin
            state_d    = ERR;
            lane_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= IDLE;
            lane_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_err_q <= lane_err_d;
        end
    end

    assign lane_err = lane_err_q;
    assign idle     = (state_q == IDLE);

`ifdef UNSTRIPE_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            err_cnt_q <= '0;
        end else if (w_err_evt && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_unstripe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_unstripe_ctrl : queue-based reference model, directed + random    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_unstripe_ctrl;

    localparam int WIDTH    = 32;
    localparam int DEPTH    = 4;
    localparam int SKEW_MAX = 2;

    logic             clk = 1'b0;
    logic             reset_L = 1'b0;
    logic             valid_0 = 1'b0;
    logic [WIDTH-1:0] lane_0 = '0;
    logic             valid_1 = 1'b0;
    logic [WIDTH-1:0] lane_1 = '0;
    logic             ready_in = 1'b0;
    logic             clear_err = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             lane_err;
    logic             idle;
`ifdef UNSTRIPE_ERR_CNT_EN
    logic [7:0]       err_count;
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference model: lane queues, which lane is owed next, error flag.
    logic [WIDTH-1:0] mq0[$];
    logic [WIDTH-1:0] mq1[$];
    int               m_want   = 0;   // 0 nothing owed, 1 lane0 word, 2 lane1 word
    bit               m_err    = 1'b0;
    int               m_errcnt = 0;

    unstripe_ctrl #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .SKEW_MAX (SKEW_MAX)
    ) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .valid_0   (valid_0),
        .lane_0    (lane_0),
        .valid_1   (valid_1),
        .lane_1    (lane_1),
        .ready_in  (ready_in),
        .clear_err (clear_err),
        .data_out  (data_out),
        .valid_out (valid_out),
        .lane_err  (lane_err),
        .idle      (idle)
`ifdef UNSTRIPE_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic [31:0] d0, input logic v1,
                         input logic [31:0] d1, input logic rdy, input logic clr);
        valid_0   = v0;
        lane_0    = d0;
        valid_1   = v1;
        lane_1    = d1;
        ready_in  = rdy;
        clear_err = clr;
    endtask

    task automatic model_step();
        int  pre0;
        int  pre1;
        int  diff;
        bit  p0;
        bit  p1;
        bit  ovf;
        if (m_err) begin
            if (clear_err) m_err = 1'b0;
            return;
        end
        pre0 = mq0.size();
        pre1 = mq1.size();
        p0   = (m_want == 1) && ready_in;
        p1   = (m_want == 2) && ready_in;
        if (p0) void'(mq0.pop_front());
        if (p1) void'(mq1.pop_front());
        ovf = 1'b0;
        if (valid_0) begin
            if (mq0.size() < DEPTH) mq0.push_back(lane_0);
            else ovf = 1'b1;
        end
        if (valid_1) begin
            if (mq1.size() < DEPTH) mq1.push_back(lane_1);
            else ovf = 1'b1;
        end
        diff = mq0.size() - mq1.size();
        if (diff < 0) diff = -diff;
        if (ovf || diff > SKEW_MAX) begin
            m_err  = 1'b1;
            m_want = 0;
            mq0.delete();
            mq1.delete();
            if (m_errcnt < 255) m_errcnt++;
            return;
        end
        if (m_want == 0) begin
            if (pre0 > 0 && pre1 > 0) m_want = 1;
        end else if (m_want == 1) begin
            if (p0) m_want = 2;
        end else if (p1) begin
            m_want = (mq0.size() > 0 && mq1.size() > 0) ? 1 : 0;
        end
    endtask

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            mq0.delete();
            mq1.delete();
            m_want   = 0;
            m_err    = 1'b0;
            m_errcnt = 0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        logic [31:0] ed;
        bit          ev;
        if (chk_en) begin
            ev = !m_err && (m_want != 0);
            ed = '0;
            if (m_want == 1 && mq0.size() > 0) ed = mq0[0];
            if (m_want == 2 && mq1.size() > 0) ed = mq1[0];
            chk("valid_out", 32'(valid_out), 32'(ev));
            chk("data_out", data_out, ed);
            chk("idle", 32'(idle), 32'(!m_err && m_want == 0));
            chk("lane_err", 32'(lane_err), 32'(m_err));
`ifdef UNSTRIPE_ERR_CNT_EN
            chk("err_count", 32'(err_count), 32'(m_errcnt));
`endif
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit v0;
        bit v1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_err", 32'(lane_err), 32'd0);
        reset_L = 1'b1;

        // Basic pair ordering.
        @(negedge clk); drive(1, 32'hA000_0000, 1, 32'hB000_0000, 1, 0);
        @(negedge clk); drive(1, 32'hA000_0001, 1, 32'hB000_0001, 1, 0);
        @(negedge clk); drive(0, 0, 0, 0, 1, 0);
        chk("ord_a0", data_out, 32'hA000_0000);
        chk("ord_v", 32'(valid_out), 32'd1);
        @(negedge clk); chk("ord_b0", data_out, 32'hB000_0000);
        @(negedge clk); chk("ord_a1", data_out, 32'hA000_0001);
        @(negedge clk); chk("ord_b1", data_out, 32'hB000_0001);
        @(negedge clk); chk("ord_idle", 32'(idle), 32'd1);

        // Backpressure hold.
        drive(1, 32'hA1A1_0000, 1, 32'hB1B1_0000, 0, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("hold_data", data_out, 32'hA1A1_0000);
            chk("hold_valid", 32'(valid_out), 32'd1);
        end
        ready_in = 1'b1;
        @(negedge clk); chk("hold_b0", data_out, 32'hB1B1_0000);
        @(negedge clk); chk("hold_idle", 32'(idle), 32'd1);

        // Skew error from lane 0 only, then clear.
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'hC000_0000 + i, 0, 0, 1, 0);
            @(negedge clk);
        end
        chk("skew_err", 32'(lane_err), 32'd1);
        chk("skew_valid", 32'(valid_out), 32'd0);
        chk("skew_notidle", 32'(idle), 32'd0);
        drive(0, 0, 0, 0, 1, 1);
        @(negedge clk); drive(0, 0, 0, 0, 1, 0);
        chk("clr_idle", 32'(idle), 32'd1);
        chk("clr_err", 32'(lane_err), 32'd0);

        // Overflow of both FIFOs under backpressure, then flush check.
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'hD000_0000 + i, 1, 32'hE000_0000 + i, 0, 0);
            @(negedge clk);
        end
        chk("ovf_err", 32'(lane_err), 32'd1);
        chk("ovf_valid", 32'(valid_out), 32'd0);
        drive(0, 0, 0, 0, 1, 1);
        @(negedge clk); chk("ovf_idle", 32'(idle), 32'd1);
        drive(1, 32'hE0E0_0000, 1, 32'hF0F0_0000, 1, 0);
        @(negedge clk); drive(0, 0, 0, 0, 1, 0);
        @(negedge clk); chk("flush_e0", data_out, 32'hE0E0_0000);
        @(negedge clk); chk("flush_f0", data_out, 32'hF0F0_0000);

        // Reset mid-stream.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(1, 32'h1111_0000 + i, 1, 32'h2222_0000 + i, 1, 0);
        end
        @(negedge clk); drive(0, 0, 0, 0, 1, 0);
        #1 reset_L = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(valid_out), 32'd0);
        chk("mid_rst_data", data_out, 32'd0);
        chk("mid_rst_idle", 32'(idle), 32'd1);
        @(negedge clk); reset_L = 1'b1;
        @(negedge clk); drive(1, 32'h3333_0000, 1, 32'h4444_0000, 1, 0);
        @(negedge clk); drive(0, 0, 0, 0, 1, 0);
        @(negedge clk); chk("post_rst_c0", data_out, 32'h3333_0000);
        @(negedge clk); chk("post_rst_d0", data_out, 32'h4444_0000);
        @(negedge clk);

        // Three error entries after reset.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) begin
                drive(1, 32'h5000_0000 + i, 0, 0, 1, 0);
                @(negedge clk);
            end
            drive(0, 0, 0, 0, 1, 1);
            @(negedge clk); drive(0, 0, 0, 0, 1, 0);
        end
`ifdef UNSTRIPE_ERR_CNT_EN
        chk("err_count_3", 32'(err_count), 32'd3);
`endif
        chk("err3_idle", 32'(idle), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            v0 = ($urandom_range(0, 3) == 0);
            v1 = ($urandom_range(0, 9) < 8) ? v0 : ($urandom_range(0, 3) == 0);
            drive(v0, $urandom, v1, $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0);
        end
        @(negedge clk); drive(0, 0, 0, 0, 1, 0);
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
